// File: rtl/vga_timing_ctrl.sv
// 640x480@60 raster timing generator; issues pixel coordinates to the page generators
// and re-times their pixel data so RGB and sync reach the connector on the same clock.
module vga_timing_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int PIX_LAT   = 1
) (
  input  logic        vga_clk,
  input  logic        vga_rst_n,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        frame_start,
  input  logic [11:0] pixel_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP_S = 10'(H_VISIBLE);
  localparam logic [9:0] H_SY_S = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_BP_S = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_S = 10'(V_VISIBLE);
  localparam logic [9:0] V_SY_S = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_BP_S = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {PH_VIS, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  logic [9:0] r_h_cnt, r_v_cnt;
  logic [9:0] w_h_nxt, w_v_nxt;
  logic       w_h_last, w_v_last;
  phase_t     w_h_phase, w_v_phase;
  logic       w_vis0, w_hs0, w_vs0;

  logic [PIX_LAT-1:0] r_vis_pipe, r_hs_pipe, r_vs_pipe;
  logic               w_vis_d, w_hs_d, w_vs_d;

  assign w_h_last = (r_h_cnt == H_MAX);
  assign w_v_last = (r_v_cnt == V_MAX);
  assign w_h_nxt  = w_h_last ? 10'd0 : r_h_cnt + 10'd1;
  assign w_v_nxt  = !w_h_last ? r_v_cnt : (w_v_last ? 10'd0 : r_v_cnt + 10'd1);

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      frame_start <= 1'b0;
    end else begin
      r_h_cnt     <= w_h_nxt;
      r_v_cnt     <= w_v_nxt;
      // Registered from the next count so it lines up with the (0,0) request itself.
      frame_start <= (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
    end
  end

  // Phases are pure decodes of the counters; the vertical one moves only when v_cnt does.
  always_comb begin
    w_h_phase = PH_BACK;
    if (r_h_cnt < H_FP_S)      w_h_phase = PH_VIS;
    else if (r_h_cnt < H_SY_S) w_h_phase = PH_FRONT;
    else if (r_h_cnt < H_BP_S) w_h_phase = PH_SYNC;
  end

  always_comb begin
    w_v_phase = PH_BACK;
    if (r_v_cnt < V_FP_S)      w_v_phase = PH_VIS;
    else if (r_v_cnt < V_SY_S) w_v_phase = PH_FRONT;
    else if (r_v_cnt < V_BP_S) w_v_phase = PH_SYNC;
  end

  assign x_pos  = (w_h_phase == PH_VIS) ? r_h_cnt : 10'd0;
  assign y_pos  = (w_v_phase == PH_VIS) ? r_v_cnt : 10'd0;
  assign w_vis0 = (w_h_phase == PH_VIS) && (w_v_phase == PH_VIS);
  assign w_hs0  = (w_h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign w_vs0  = (w_v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;

  // Delay control by the page generator latency so it meets the matching pixel_data.
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_vis_pipe <= '0;
      r_hs_pipe  <= {PIX_LAT{~SYNC_POL}};
      r_vs_pipe  <= {PIX_LAT{~SYNC_POL}};
    end else begin
      r_vis_pipe[0] <= w_vis0;
      r_hs_pipe[0]  <= w_hs0;
      r_vs_pipe[0]  <= w_vs0;
      for (int i = 1; i < PIX_LAT; i++) begin
        r_vis_pipe[i] <= r_vis_pipe[i-1];
        r_hs_pipe[i]  <= r_hs_pipe[i-1];
        r_vs_pipe[i]  <= r_vs_pipe[i-1];
      end
    end
  end

  assign w_vis_d = r_vis_pipe[PIX_LAT-1];
  assign w_hs_d  = r_hs_pipe[PIX_LAT-1];
  assign w_vs_d  = r_vs_pipe[PIX_LAT-1];

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_de <= 1'b0;
      vga_hs <= ~SYNC_POL;
      vga_vs <= ~SYNC_POL;
    end else begin
      {vga_b, vga_g, vga_r} <= w_vis_d ? pixel_data : 12'h000;
      vga_de <= w_vis_d;
      vga_hs <= w_hs_d;
      vga_vs <= w_vs_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size instance fed by a 1-clk x_pos pixel model and a
// shrunk instance fed random pixels, both compared every clock to an arithmetic raster model.
module tb_vga_timing_ctrl;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        de;
    logic [11:0] rgb;
  } vec_t;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_a, rst_b;
  logic [11:0] pd_a, pd_b;
  logic [9:0]  xa, ya, xb, yb;
  logic        fsa, fsb, hsa, hsb, vsa, vsb, dea, deb;
  logic [3:0]  ra, ga, ba, rb, gb, bb;

  vga_timing_ctrl u_a (
    .vga_clk(clk), .vga_rst_n(rst_a), .x_pos(xa), .y_pos(ya), .frame_start(fsa),
    .pixel_data(pd_a), .vga_r(ra), .vga_g(ga), .vga_b(ba), .vga_hs(hsa), .vga_vs(vsa),
    .vga_de(dea)
  );

  vga_timing_ctrl #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIX_LAT(2)
  ) u_b (
    .vga_clk(clk), .vga_rst_n(rst_b), .x_pos(xb), .y_pos(yb), .frame_start(fsb),
    .pixel_data(pd_b), .vga_r(rb), .vga_g(gb), .vga_b(bb), .vga_hs(hsb), .vga_vs(vsb),
    .vga_de(deb)
  );

  // Page generator stand-in: registered copy of the requested column.
  always @(posedge clk) pd_a <= {2'b00, xa};

  int errors = 0;
  int checks = 0;
  int na = 0, nb = 0;
  logic [11:0] lpa, lpb;
  int mode_fff = 0;
  int hs_lo_a, first_hs_a, de_cnt_b, fs_cnt_b;

  // n = clocks since reset release; pdp = pixel_data captured on the edge ending cycle n-1.
  function automatic exp_t model(int hv, int hf, int hsw, int hb, int vv, int vf, int vsw,
                                 int vb, int lat, int n, logic [11:0] pdp);
    exp_t e;
    int ht = hv + hf + hsw + hb;
    int vt = vv + vf + vsw + vb;
    int h = n % ht, v = (n / ht) % vt, m = n - lat - 1;
    e.x  = (h < hv) ? 10'(h) : 10'd0;
    e.y  = (v < vv) ? 10'(v) : 10'd0;
    e.fs = (n > 0) && (h == 0) && (v == 0);
    if (m < 0) begin
      e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.rgb = 12'h000;
    end else begin
      int hm = m % ht, vm = (m / ht) % vt;
      e.de  = (hm < hv) && (vm < vv);
      e.hs  = !((hm >= hv + hf) && (hm < hv + hf + hsw));
      e.vs  = !((vm >= vv + vf) && (vm < vv + vf + vsw));
      e.rgb = e.de ? pdp : 12'h000;
    end
    return e;
  endfunction

  function automatic exp_t act_a();
    exp_t e;
    e.x = xa; e.y = ya; e.fs = fsa; e.de = dea; e.hs = hsa; e.vs = vsa; e.rgb = {ba, ga, ra};
    return e;
  endfunction

  function automatic exp_t act_b();
    exp_t e;
    e.x = xb; e.y = yb; e.fs = fsb; e.de = deb; e.hs = hsb; e.vs = vsb; e.rgb = {bb, gb, rb};
    return e;
  endfunction

  task automatic chk(string nm, int n, exp_t act, exp_t expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s n=%0d got x=%0d y=%0d fs=%b de=%b hs=%b vs=%b rgb=%h want x=%0d y=%0d fs=%b de=%b hs=%b vs=%b rgb=%h",
               nm, n, act.x, act.y, act.fs, act.de, act.hs, act.vs, act.rgb,
               expv.x, expv.y, expv.fs, expv.de, expv.hs, expv.vs, expv.rgb);
    end
  endtask

  task automatic chk_int(string nm, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_a) na++;
    if (rst_b) nb++;
    chk("rasterA", na, act_a(), model(640, 16, 96, 48, 480, 10, 2, 33, 1, na, lpa));
    chk("rasterB", nb, act_b(), model(8, 2, 3, 3, 4, 1, 2, 1, 2, nb, lpb));
    if (rst_a && na < 800 && !hsa) begin
      hs_lo_a++;
      if (first_hs_a < 0) first_hs_a = na;
    end
    if (rst_b) begin
      de_cnt_b += int'(deb);
      fs_cnt_b += int'(fsb);
    end
    lpa  = pd_a;
    pd_b = (mode_fff != 0) ? 12'hfff : 12'($urandom);
    lpb  = pd_b;
  endtask

  task automatic drop_a();
    rst_a = 1'b0;
    na    = 0;
    #1 chk("asyncA", na, act_a(), model(640, 16, 96, 48, 480, 10, 2, 33, 1, 0, 12'h000));
  endtask

  task automatic drop_b();
    rst_b = 1'b0;
    nb    = 0;
    #1 chk("asyncB", nb, act_b(), model(8, 2, 3, 3, 4, 1, 2, 1, 2, 0, 12'h000));
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{cyc: 5,    x: 10'd5,   y: 10'd0, hs: 1'b1, de: 1'b1, rgb: 12'h003};
    tbl[1]  = '{cyc: 100,  x: 10'd100, y: 10'd0, hs: 1'b1, de: 1'b1, rgb: 12'h062};
    tbl[2]  = '{cyc: 639,  x: 10'd639, y: 10'd0, hs: 1'b1, de: 1'b1, rgb: 12'h27d};
    tbl[3]  = '{cyc: 641,  x: 10'd0,   y: 10'd0, hs: 1'b1, de: 1'b1, rgb: 12'h27f};
    tbl[4]  = '{cyc: 642,  x: 10'd0,   y: 10'd0, hs: 1'b1, de: 1'b0, rgb: 12'h000};
    tbl[5]  = '{cyc: 657,  x: 10'd0,   y: 10'd0, hs: 1'b1, de: 1'b0, rgb: 12'h000};
    tbl[6]  = '{cyc: 658,  x: 10'd0,   y: 10'd0, hs: 1'b0, de: 1'b0, rgb: 12'h000};
    tbl[7]  = '{cyc: 753,  x: 10'd0,   y: 10'd0, hs: 1'b0, de: 1'b0, rgb: 12'h000};
    tbl[8]  = '{cyc: 754,  x: 10'd0,   y: 10'd0, hs: 1'b1, de: 1'b0, rgb: 12'h000};
    tbl[9]  = '{cyc: 800,  x: 10'd0,   y: 10'd1, hs: 1'b1, de: 1'b0, rgb: 12'h000};
    tbl[10] = '{cyc: 802,  x: 10'd2,   y: 10'd1, hs: 1'b1, de: 1'b1, rgb: 12'h000};
    tbl[11] = '{cyc: 1000, x: 10'd200, y: 10'd1, hs: 1'b1, de: 1'b1, rgb: 12'h0c6};
    tbl[12] = '{cyc: 1001, x: 10'd201, y: 10'd1, hs: 1'b1, de: 1'b1, rgb: 12'h0c7};

    rst_a = 1'b0; rst_b = 1'b0; pd_b = 12'h000; lpa = 12'h000; lpb = 12'h000;
    hs_lo_a = 0; first_hs_a = -1; de_cnt_b = 0; fs_cnt_b = 0;
    repeat (3) tick();

    rst_a = 1'b1; rst_b = 1'b1;
    for (int i = 0; i < 13; i++) begin
      while (na < tbl[i].cyc) tick();
      checks++;
      if ({xa, ya, hsa, dea, ba, ga, ra} !== {tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].de, tbl[i].rgb}) begin
        errors++;
        $display("FAIL vec%0d cyc=%0d got x=%0d y=%0d hs=%b de=%b rgb=%h want x=%0d y=%0d hs=%b de=%b rgb=%h",
                 i, tbl[i].cyc, xa, ya, hsa, dea, {ba, ga, ra},
                 tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].de, tbl[i].rgb);
      end
    end
    chk_int("hs_low_len", hs_lo_a, 96);
    chk_int("hs_first", first_hs_a, 658);

    // Drop reset while the full-size hs pulse is on the pins, then re-time line 0.
    while (na < 1500) tick();
    chk_int("hs_low_before_drop", int'(hsa), 0);
    drop_a();
    repeat (2) tick();
    rst_a = 1'b1; hs_lo_a = 0; first_hs_a = -1;
    repeat (800) tick();
    chk_int("hs_low_len_rst", hs_lo_a, 96);
    chk_int("hs_first_rst", first_hs_a, 658);

    // Small raster: five whole frames of white pixels, then random pixels with random resets.
    mode_fff = 1;
    drop_b();
    tick();
    rst_b = 1'b1; de_cnt_b = 0; fs_cnt_b = 0;
    repeat (640) tick();
    chk_int("de_per_5frames", de_cnt_b, 160);
    chk_int("fs_per_5frames", fs_cnt_b, 5);

    for (int k = 0; k < 8; k++) begin
      mode_fff = k % 2;
      repeat ($urandom_range(50, 400)) tick();
      drop_b();
      repeat ($urandom_range(1, 3)) tick();
      rst_b = 1'b1;
    end
    repeat (300) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
